// File: rtl/seg7_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seg7_pkg
// Description : Active-low 7-segment patterns and bit ordering, shared by the
//               display driver and the capture monitor.
// Revision    : 1.0 - initial release
// ============================================================================
package seg7_pkg;

    // Patterns are {a,b,c,d,e,f,g}, a segment is lit when its bit is 0
    localparam logic [6:0] SEG_PAT_0     = 7'b0000001;
    localparam logic [6:0] SEG_PAT_1     = 7'b1001111;
    localparam logic [6:0] SEG_PAT_2     = 7'b0010010;
    localparam logic [6:0] SEG_PAT_3     = 7'b0000110;
    localparam logic [6:0] SEG_PAT_4     = 7'b1001100;
    localparam logic [6:0] SEG_PAT_5     = 7'b0100100;
    localparam logic [6:0] SEG_PAT_6     = 7'b0100000;
    localparam logic [6:0] SEG_PAT_7     = 7'b0001111;
    localparam logic [6:0] SEG_PAT_8     = 7'b0000000;
    localparam logic [6:0] SEG_PAT_9     = 7'b0000100;
    localparam logic [6:0] SEG_PAT_BLANK = 7'b1111111;

    localparam logic [3:0] BLANK_NIBBLE  = 4'hF;

    localparam int SEG_BIT_A  = 7;
    localparam int SEG_BIT_B  = 6;
    localparam int SEG_BIT_C  = 5;
    localparam int SEG_BIT_D  = 4;
    localparam int SEG_BIT_E  = 3;
    localparam int SEG_BIT_F  = 2;
    localparam int SEG_BIT_G  = 1;
    localparam int SEG_BIT_DP = 0;

endpackage
`default_nettype wire

// File: rtl/seg7_pattern_dec.sv
`default_nettype none
// ============================================================================
// Module      : seg7_pattern_dec
// Description : Combinational inverse of the driver table: segment pattern
//               to BCD nibble with legal / blank flags.
// Revision    : 1.0 - initial release
// ============================================================================
module seg7_pattern_dec
    import seg7_pkg::*;
(
    input  logic [6:0] i_seg,
    output logic [3:0] o_nibble,
    output logic       o_is_legal,
    output logic       o_is_blank
);

    always_comb begin
        o_nibble   = 4'h0;
        o_is_legal = 1'b1;
        o_is_blank = 1'b0;
        case (i_seg)
            SEG_PAT_0:     o_nibble = 4'd0;
            SEG_PAT_1:     o_nibble = 4'd1;
            SEG_PAT_2:     o_nibble = 4'd2;
            SEG_PAT_3:     o_nibble = 4'd3;
            SEG_PAT_4:     o_nibble = 4'd4;
            SEG_PAT_5:     o_nibble = 4'd5;
            SEG_PAT_6:     o_nibble = 4'd6;
            SEG_PAT_7:     o_nibble = 4'd7;
            SEG_PAT_8:     o_nibble = 4'd8;
            SEG_PAT_9:     o_nibble = 4'd9;
            SEG_PAT_BLANK: begin
                o_nibble   = BLANK_NIBBLE;
                o_is_blank = 1'b1;
            end
            default:       o_is_legal = 1'b0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/seg7_capture.sv
`default_nettype none
// ============================================================================
// Module      : seg7_capture
// Description : Samples a multiplexed active-low 4-digit 7-segment bus,
//               filters glitches and holds a decoded nibble per digit with
//               validity and age tracking. Define SEG7_CAPTURE_DP_EN to also
//               capture the decimal point of each digit.
// Revision    : 1.0 - initial release
// ============================================================================
module seg7_capture
    import seg7_pkg::*;
#(
    parameter int STABLE_CYC  = 16,
    parameter int TIMEOUT_CYC = 192000
)(
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] AN,
    input  logic [7:0] SEG,
    output logic [3:0] dout0,
    output logic [3:0] dout1,
    output logic [3:0] dout2,
    output logic [3:0] dout3,
    output logic [3:0] valid,
    output logic [3:0] blank,
    output logic       upd,
    output logic       err
`ifdef SEG7_CAPTURE_DP_EN
    ,
    output logic [3:0] dp
`endif
);

`ifdef SEG7_CAPTURE_DP_EN
    localparam int c_W = 12;
    logic [c_W-1:0] w_in;
    assign w_in = {AN, SEG};
`else
    localparam int c_W = 11;
    logic [c_W-1:0] w_in;
    logic           w_unused_dp;
    assign w_in        = {AN, SEG[7:1]};
    assign w_unused_dp = SEG[0];
`endif

    localparam int c_CNT_W = $clog2(STABLE_CYC + 1);
    localparam int c_AGE_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(STABLE_CYC);
    localparam logic [c_AGE_W-1:0] c_AGE_MAX = c_AGE_W'(TIMEOUT_CYC);

    logic [c_W-1:0]     r_sync1;
    logic [c_W-1:0]     r_sync2;
    logic [c_W-1:0]     r_sd;
    logic [c_W-1:0]     r_word;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_pend;

    // Pending flag marks the edge the window completes; outputs follow one edge later
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= {c_W{1'b1}};
            r_sync2 <= {c_W{1'b1}};
            r_sd    <= {c_W{1'b1}};
            r_word  <= {c_W{1'b1}};
            r_cnt   <= '0;
            r_pend  <= 1'b0;
        end else begin
            r_sync1 <= w_in;
            r_sync2 <= r_sync1;
            r_sd    <= r_sync2;
            r_pend  <= 1'b0;
            if (r_sync2 != r_sd) begin
                r_cnt <= '0;
            end else if (r_cnt != c_CNT_MAX) begin
                r_cnt <= r_cnt + 1'b1;
                if (r_cnt == c_CNT_MAX - 1'b1) begin
                    r_pend <= 1'b1;
                    r_word <= r_sd;
                end
            end
        end
    end

    logic [3:0] w_an_n;
    logic       w_one_hot;
    logic       w_multi;
    logic [3:0] w_sel;
    logic [3:0] w_nibble;
    logic       w_legal;
    logic       w_is_blank;

    assign w_an_n    = ~r_word[c_W-1 -: 4];
    assign w_one_hot = (w_an_n != 4'b0000) && ((w_an_n & (w_an_n - 4'd1)) == 4'b0000);
    assign w_multi   = (w_an_n != 4'b0000) && !w_one_hot;
    assign w_sel     = (r_pend && w_one_hot) ? w_an_n : 4'b0000;

    seg7_pattern_dec u_dec (
        .i_seg      (r_word[c_W-5 -: 7]),
        .o_nibble   (w_nibble),
        .o_is_legal (w_legal),
        .o_is_blank (w_is_blank)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            upd <= 1'b0;
            err <= 1'b0;
        end else begin
            upd <= r_pend && w_one_hot && w_legal;
            err <= r_pend && (w_multi || (w_one_hot && !w_legal));
        end
    end

    logic [3:0] w_dout [4];

    generate
        for (genvar i = 0; i < 4; i++) begin : g_digit
            logic [3:0]         r_dout;
            logic               r_valid;
            logic               r_blank;
            logic [c_AGE_W-1:0] r_age;

            // A capture attempt outranks a timeout landing on the same edge
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_dout  <= 4'h0;
                    r_valid <= 1'b0;
                    r_blank <= 1'b0;
                    r_age   <= '0;
                end else if (w_sel[i]) begin
                    r_age <= '0;
                    if (w_legal) begin
                        r_dout  <= w_nibble;
                        r_valid <= 1'b1;
                        r_blank <= w_is_blank;
                    end else begin
                        r_valid <= 1'b0;
                    end
                end else if (r_age != c_AGE_MAX) begin
                    r_age <= r_age + 1'b1;
                    if (r_age == c_AGE_MAX - 1'b1) begin
                        r_valid <= 1'b0;
                    end
                end
            end

            assign w_dout[i] = r_dout;
            assign valid[i]  = r_valid;
            assign blank[i]  = r_blank;

`ifdef SEG7_CAPTURE_DP_EN
            logic r_dp;
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_dp <= 1'b0;
                end else if (w_sel[i] && w_legal) begin
                    r_dp <= ~r_word[0];
                end
            end
            assign dp[i] = r_dp;
`endif
        end
    endgenerate

    assign dout0 = w_dout[0];
    assign dout1 = w_dout[1];
    assign dout2 = w_dout[2];
    assign dout3 = w_dout[3];

endmodule
`default_nettype wire
